// File: rtl/cordic_issue_seq.sv
// cordic_issue_seq: issues one operand at a time to the CORDIC accelerator
// and returns its result (or a qNaN on timeout) on an output stream.
module cordic_issue_seq #(
  parameter int FIXED_LAT = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        acc_start,
  output logic [31:0] acc_x,
  input  logic        acc_done,
  input  logic [31:0] acc_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        busy,
  output logic [15:0] done_cnt,
  output logic [7:0]  err_cnt
);

  localparam bit FIX = FIXED_LAT > 0;
  localparam int LIM = FIX ? FIXED_LAT : TIMEOUT;
  localparam int CW  = $clog2(LIM + 1);
  localparam logic [CW-1:0] LAST = CW'(LIM - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   x_q, x_d;
  logic [31:0]   y_q, y_d;
  logic          err_q, err_d;
  logic [15:0]   dcnt_q, dcnt_d;
  logic [7:0]    ecnt_q, ecnt_d;

  // next-state and datapath decode from the current registered state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    dcnt_d  = dcnt_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (FIX) begin
          if (cnt_q == LAST) begin
            y_d     = acc_y;
            err_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (acc_done) begin
          y_d     = acc_y;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == LAST) begin
          y_d     = QNAN;
          err_d   = 1'b1;
          state_d = HOLD;
          if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          dcnt_d  = dcnt_q + 16'd1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // state and data registers, all gated by clk_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      dcnt_q  <= '0;
      ecnt_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      dcnt_q  <= dcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign acc_start = state_q == ISSUE;
  assign out_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign acc_x     = x_q;
  assign out_data  = y_q;
  assign out_err   = err_q;
  assign done_cnt  = dcnt_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_cordic_issue_seq.sv
// tb_cordic_issue_seq: table, hand-written and random checks of
// cordic_issue_seq in done mode (TIMEOUT=8) and fixed mode (FIXED_LAT=16).
module tb_cordic_issue_seq;

  localparam int TO = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_en, in_valid, in_ready, acc_start, acc_done;
  logic        out_valid, out_ready, out_err, busy;
  logic [31:0] in_data, acc_x, acc_y, out_data;
  logic [15:0] done_cnt;
  logic [7:0]  err_cnt;

  logic        f_in_valid, f_in_ready, f_acc_start, f_acc_done;
  logic        f_out_valid, f_out_ready, f_out_err, f_busy;
  logic [31:0] f_in_data, f_acc_x, f_acc_y, f_out_data;
  logic [15:0] f_done_cnt;
  logic [7:0]  f_err_cnt;

  cordic_issue_seq #(.FIXED_LAT(0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_start(acc_start), .acc_x(acc_x),
    .acc_done(acc_done), .acc_y(acc_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy),
    .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  cordic_issue_seq #(.FIXED_LAT(16)) dut_f (
    .clk(clk), .reset(reset), .clk_en(1'b1),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
    .acc_start(f_acc_start), .acc_x(f_acc_x),
    .acc_done(f_acc_done), .acc_y(f_acc_y),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_data(f_out_data), .out_err(f_out_err), .busy(f_busy),
    .done_cnt(f_done_cnt), .err_cnt(f_err_cnt)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] exp_done = 0;
  logic [7:0]  exp_err = 0;

  typedef struct {
    logic [31:0] x;
    int          l;
    logic [31:0] y;
    int          hold;
    int          lat;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one done-mode operation; acc answers l cycles after its start cycle
  task automatic op(input logic [31:0] x, input int l,
                    input logic [31:0] y, input int hold,
                    input logic nv, input logic [31:0] nd,
                    output int got_lat, output logic [31:0] got_d,
                    output logic got_e);
    int c, starts;
    bit xbad, hbad;
    logic [31:0] d0;
    logic e0;
    bit tmo;
    tmo = l > TO;
    in_valid = 1'b1;
    in_data = x;
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data = $urandom;
    c = 1;
    starts = 0;
    xbad = 0;
    got_lat = -1;
    while (c <= TO + 8) begin
      if (acc_start) starts++;
      if (acc_x !== x) xbad = 1;
      if (out_valid) begin
        got_lat = c;
        break;
      end
      acc_done = (c == 1 + l);
      acc_y = (c == 1 + l) ? y : $urandom;
      step();
      c++;
    end
    acc_done = 1'b0;
    got_d = out_data;
    got_e = out_err;
    if (tmo && exp_err != 8'hFF) exp_err++;
    chk("start_pulses", starts, 1);
    chk("acc_x_stable", 32'(xbad), 0);
    chk("err_cnt", err_cnt, exp_err);
    d0 = out_data;
    e0 = out_err;
    hbad = 0;
    in_valid = nv;
    in_data = nd;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!out_valid || in_ready || out_data !== d0 ||
          out_err !== e0 || done_cnt !== exp_done) hbad = 1;
    end
    chk("hold_stable", 32'(hbad), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_done++;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
    chk("done_cnt", done_cnt, exp_done);
    chk("x_not_taken", acc_x, x);
  endtask

  task automatic fop(input logic [31:0] x, input logic [15:0] edone);
    int c, starts;
    f_in_valid = 1'b1;
    f_in_data = x;
    step();
    f_in_valid = 1'b0;
    c = 1;
    starts = 0;
    while (!f_out_valid && c < 40) begin
      if (f_acc_start) starts++;
      f_acc_y = 32'hA000_0000 | 32'(c);
      step();
      c++;
    end
    chk("f_lat", c, 18);
    chk("f_starts", starts, 1);
    chk("f_data", f_out_data, 32'hA000_0011);
    chk("f_err", f_out_err, 0);
    chk("f_acc_x", f_acc_x, x);
    f_out_ready = 1'b1;
    step();
    f_out_ready = 1'b0;
    chk("f_valid_drop", f_out_valid, 0);
    chk("f_done_cnt", f_done_cnt, edone);
  endtask

  int lat, n;
  logic [31:0] d, mx, my;
  logic e;
  int ml;

  initial begin
    tbl[0] = '{32'h4360_0000, 3,  32'h3F80_0000, 0, 5,  32'h3F80_0000, 1'b0};
    tbl[1] = '{32'h4049_0FDB, 1,  32'h3F00_0000, 2, 3,  32'h3F00_0000, 1'b0};
    tbl[2] = '{32'hC120_0000, 8,  32'hBF80_0000, 1, 10, 32'hBF80_0000, 1'b0};
    tbl[3] = '{32'h3DCC_CCCD, 9,  32'h1234_5678, 0, 10, QNAN,          1'b1};
    tbl[4] = '{32'h0000_0000, 50, 32'h5555_AAAA, 3, 10, QNAN,          1'b1};
    tbl[5] = '{32'h7F80_0000, 7,  32'h0000_0001, 0, 9,  32'h0000_0001, 1'b0};

    reset = 1'b0;
    clk_en = 1'b1;
    in_valid = 0; in_data = 0; acc_done = 0; acc_y = 0; out_ready = 0;
    f_in_valid = 0; f_in_data = 0; f_acc_done = 1'b1; f_acc_y = 0;
    f_out_ready = 0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", acc_start, 0);
    chk("rst_acc_x", acc_x, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      op(tbl[i].x, tbl[i].l, tbl[i].y, tbl[i].hold, 1'b0, 32'h0,
         lat, d, e);
      chk("tbl_lat", lat, tbl[i].lat);
      chk("tbl_data", d, tbl[i].data);
      chk("tbl_err", e, tbl[i].err);
    end

    op(32'h1111_1111, 4, 32'h2222_2222, 5, 1'b1, 32'h3333_3333, lat, d, e);
    chk("b2b_lat", lat, 6);
    chk("b2b_data", d, 32'h2222_2222);
    op(32'h3333_3333, 2, 32'h4444_4444, 0, 1'b0, 32'h0, lat, d, e);
    chk("b2b2_lat", lat, 4);
    chk("b2b2_data", d, 32'h4444_4444);

    in_valid = 1'b1;
    in_data = 32'h5151_5151;
    step();
    in_valid = 1'b0;
    clk_en = 1'b0;
    step();
    chk("ce_start_hold1", acc_start, 1);
    step();
    chk("ce_start_hold2", acc_start, 1);
    clk_en = 1'b1;
    step();
    chk("ce_start_off", acc_start, 0);
    step();
    step();
    clk_en = 1'b0;
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!busy || out_valid) e = 1'b1;
    end
    chk("ce_wait_frozen", e, 0);
    clk_en = 1'b1;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    exp_err++;
    chk("ce_wait_left", n, 6);
    chk("ce_tmo_data", out_data, QNAN);
    chk("ce_tmo_err", out_err, 1);
    chk("ce_err_cnt", err_cnt, exp_err);
    out_ready = 1'b1;
    clk_en = 1'b0;
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!out_valid || done_cnt !== exp_done) e = 1'b1;
    end
    chk("ce_hold_frozen", e, 0);
    clk_en = 1'b1;
    step();
    out_ready = 1'b0;
    exp_done++;
    chk("ce_hold_release", out_valid, 0);
    chk("ce_done_cnt", done_cnt, exp_done);

    for (int i = 0; i < 40; i++) begin
      mx = $urandom;
      my = $urandom;
      ml = $urandom_range(1, 12);
      op(mx, ml, my, $urandom_range(0, 3), 1'b0, 32'h0, lat, d, e);
      chk("rnd_lat", lat, 2 + ((ml <= TO) ? ml : TO));
      chk("rnd_data", d, (ml <= TO) ? my : QNAN);
      chk("rnd_err", e, (ml <= TO) ? 1'b0 : 1'b1);
    end

    for (int i = 0; i < 260; i++) begin
      op($urandom, TO + 1, 32'h0, 0, 1'b0, 32'h0, lat, d, e);
    end
    chk("err_sat", err_cnt, 8'hFF);

    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", acc_start, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_err", out_err, 0);
    chk("arst_acc_x", acc_x, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_done_cnt", done_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    step();
    reset = 1'b1;
    exp_done = 0;
    exp_err = 0;
    acc_done = 1'b1;
    acc_y = 32'hBAD0_BAD0;
    step();
    acc_done = 1'b0;
    chk("late_done_valid", out_valid, 0);
    chk("late_done_ready", in_ready, 1);
    step();
    chk("late_done_data", out_data, 0);
    op(32'h4360_0000, 3, 32'h3F80_0000, 0, 1'b0, 32'h0, lat, d, e);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_data", d, 32'h3F80_0000);

    force dut.dcnt_q = 16'hFFFF;
    step();
    step();
    release dut.dcnt_q;
    step();
    exp_done = 16'hFFFF;
    chk("preload", done_cnt, 16'hFFFF);
    op(32'h0, 2, 32'h1, 0, 1'b0, 32'h0, lat, d, e);
    chk("wrap", done_cnt, 0);

    fop(32'h4360_0000, 16'd1);
    fop(32'hC000_0000, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_issue_seq.md
# cordic_issue_seq

Requester-side sequencer for the CORDIC accelerator. It accepts IEEE-754 single-precision operands on a valid/ready stream and issues each one to the accelerator's start/x/y port. It collects the result through either a done handshake or a fixed latency, and returns it on an output valid/ready stream. It sits between the host-side operand source and the accelerator top, acting as the initiator that the accelerator's start interface expects.

## Interface
- FIXED_LAT, default 0: 0 = completion signalled by acc_done; N>0 = acc_done ignored, result sampled N cycles after the start cycle.
- TIMEOUT, default 64: maximum WAIT cycles before an error completion (done mode only); must be ≥2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_en  input  1  clock enable; low = every register holds.
- in_valid  input  1  operand available.
- in_ready  output  1  sequencer can accept an operand.
- in_data  input  32  operand, IEEE-754 single.
- acc_start  output  1  one-cycle start pulse to the accelerator.
- acc_x  output  32  operand to the accelerator.
- acc_done  input  1  accelerator completion; ignored when FIXED_LAT>0.
- acc_y  input  32  accelerator result, IEEE-754 single.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  result word.
- out_err  output  1  result is a timeout substitute; qualified by out_valid.
- busy  output  1  state ≠ IDLE.
- done_cnt  output  16  completed operations, wraps 0xFFFF→0.
- err_cnt  output  8  timeouts, saturates at 0xFF.

## Operation
- FSM states are IDLE, ISSUE, WAIT and HOLD. All outputs decode from registered state and data.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into acc_x and go to ISSUE.
- ISSUE: acc_start=1 for exactly one cycle. Clear wait counter to 0 and go to WAIT. acc_done in ISSUE is ignored.
- WAIT: counter increments each enabled cycle.
  - Done mode: if acc_done=1, latch acc_y into out_data, set out_err=0, and go to HOLD.
  - Done mode: otherwise, when counter reaches TIMEOUT-1 with no done, load out_data=32'h7FC00000 (qNaN), set out_err=1, increment err_cnt, and go to HOLD.
  - Fixed mode: when counter reaches FIXED_LAT-1, latch acc_y into out_data, set out_err=0, and go to HOLD.
- HOLD: out_valid=1, and out_data/out_err are stable. On out_ready, increment done_cnt (timeouts included) and go to IDLE.
- acc_x holds its value from the accept cycle until the next accept. It never changes while busy.
- acc_done asserted in IDLE or HOLD is ignored and produces no output.
- clk_en=0: state, counters and data all hold. acc_start keeps its current level, because the accelerator shares clk_en and sees a single enabled start cycle.
- Reset (asynchronous, any state):
  - state=IDLE.
  - acc_start, out_valid, out_err, busy = 0.
  - acc_x, out_data = 0.
  - done_cnt, err_cnt = 0.
  - A done arriving after reset is ignored.

## Timing
- Accept in cycle T: acc_start=1 in cycle T+1, and WAIT begins at T+2.
- Done mode: acc_done high in cycle D (D ≥ T+2) gives out_valid=1 from D+1.
- Fixed mode: acc_y is sampled at the end of cycle T+1+FIXED_LAT, and out_valid=1 from T+2+FIXED_LAT.
- Timeout: out_valid=1 from T+2+TIMEOUT, with out_err=1.
- out_ready high in HOLD cycle H: out_valid=0 and in_ready=1 in H+1, so the next accept can happen at H+1.
- Minimum spacing is 4 cycles per operation (accept, issue, 1 wait, hold with out_ready=1).
- in_ready=0 whenever busy, so there is no overlap or queuing. Only one operation is outstanding at a time.

## Test plan
- Done mode, in_data=32'h43600000 (224.0), accelerator model asserts done 3 cycles after start with acc_y=32'h3F800000 → single acc_start pulse, acc_x=32'h43600000 stable, out_data=32'h3F800000, out_err=0, done_cnt=1.
- FIXED_LAT=16, acc_done tied high throughout → acc_done ignored; out_valid first high exactly 18 cycles after the accept cycle.
- Done mode, TIMEOUT=8, acc_done never asserted → out_valid at T+10, out_data=32'h7FC00000, out_err=1, err_cnt=1, done_cnt=1 after out_ready.
- Back-to-back operands with out_ready held low 5 cycles → in_ready=0 throughout HOLD, second operand not accepted until the cycle after out_ready, first result unchanged while held.
- clk_en toggled low 3 cycles during WAIT and HOLD, plus reset asserted mid-WAIT → state and counters frozen while clk_en is low; after reset, all outputs are 0 immediately, a late acc_done is ignored, and the next operand completes normally.
- Preload done_cnt to 0xFFFF via 65535 quick operations (or force) then one more → done_cnt=0. err_cnt after 256 timeouts stays 0xFF.
